// File: rtl/issue_scheduler.sv
// issue_scheduler -- single-entry in-order issue stage with a register scoreboard.
//
// Holds one decoded instruction. The instruction issues to the unit named by its
// select field once the unit is ready and none of its registers is pending in
// the scoreboard. Decode exceptions park the block in EXC until acknowledged.
//
// Ports
//   clock_in, reset_n_in         clock (rising edge), async active-low reset
//   dec_valid_in / dec_ready_out decode handshake
//   exec_unit_sel_in, exec_unit_uop_in, rd_write_enable_in,
//   rd_addr_in, rs1_addr_in, rs2_addr_in, invalid_ins_in   decoded fields
//   int/bru/lsu/vec_ready_in     execution unit can accept this cycle
//   issue_valid_out, issue_sel_out, issue_uop_out,
//   issue_rd_out, issue_rd_we_out                         issue port
//   wb_valid_in, wb_rd_in        writeback retiring a pending rd
//   flush_in                     drop the buffered instruction
//   exc_valid_out / exc_ack_in   decode exception handshake
//   stall_count_out              saturating count of HELD cycles without issue
//
// NREGS may be at most 32: register fields are 5 bits wide.
module issue_scheduler #(
  parameter int NREGS = 32
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        dec_valid_in,
  output logic        dec_ready_out,
  input  logic [2:0]  exec_unit_sel_in,
  input  logic [3:0]  exec_unit_uop_in,
  input  logic        rd_write_enable_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [4:0]  rs1_addr_in,
  input  logic [4:0]  rs2_addr_in,
  input  logic        invalid_ins_in,
  input  logic        int_ready_in,
  input  logic        bru_ready_in,
  input  logic        lsu_ready_in,
  input  logic        vec_ready_in,
  output logic        issue_valid_out,
  output logic [2:0]  issue_sel_out,
  output logic [3:0]  issue_uop_out,
  output logic [4:0]  issue_rd_out,
  output logic        issue_rd_we_out,
  input  logic        wb_valid_in,
  input  logic [4:0]  wb_rd_in,
  input  logic        flush_in,
  output logic        exc_valid_out,
  input  logic        exc_ack_in,
  output logic [15:0] stall_count_out
);

  typedef enum logic [1:0] {EMPTY, HELD, EXC} state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] uop;
    logic [4:0] rd;
    logic       rd_we;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ins_t;

  state_t           state_q, state_d;
  ins_t             held_q, dec_ins;
  logic [NREGS-1:0] pend_q, pend_byp, pend_d;
  logic [31:0]      byp_w;
  logic [15:0]      stall_q;
  logic             unit_rdy, hazard, issue, accept, bad_ins;

  assign dec_ins = '{sel: exec_unit_sel_in, uop: exec_unit_uop_in, rd: rd_addr_in,
                     rd_we: rd_write_enable_in, rs1: rs1_addr_in, rs2: rs2_addr_in};

  // Scoreboard: a same-cycle writeback is bypassed into the hazard check, while
  // a same-cycle issue to the same rd wins over that writeback. x0 never pends.
  for (genvar r = 0; r < NREGS; r++) begin : g_sb
    logic wb_hit, set_hit;
    assign wb_hit      = wb_valid_in && (wb_rd_in == 5'(r));
    assign set_hit     = issue && held_q.rd_we && (held_q.rd == 5'(r));
    assign pend_byp[r] = pend_q[r] & ~wb_hit;
    if (r == 0) begin : g_x0
      assign pend_d[r] = 1'b0;
    end else begin : g_xn
      assign pend_d[r] = pend_byp[r] | set_hit;
    end
  end

  // Widen to the full 5-bit index space so any field value indexes safely.
  for (genvar r = 0; r < 32; r++) begin : g_byp
    if (r < NREGS) begin : g_in
      assign byp_w[r] = pend_byp[r];
    end else begin : g_out
      assign byp_w[r] = 1'b0;
    end
  end

  always_comb begin
    unit_rdy = 1'b0;
    case (held_q.sel)
      3'b001:  unit_rdy = int_ready_in;
      3'b011:  unit_rdy = bru_ready_in;
      3'b010:  unit_rdy = lsu_ready_in;
      3'b100:  unit_rdy = vec_ready_in;
      default: unit_rdy = 1'b0;   // unknown units never accept; only a flush clears it
    endcase
  end

  assign hazard  = byp_w[held_q.rs1] | byp_w[held_q.rs2] | (held_q.rd_we & byp_w[held_q.rd]);
  assign issue   = (state_q == HELD) && !hazard && unit_rdy && !flush_in;
  // reset_n_in gates ready so nothing is offered while reset is held.
  assign dec_ready_out = reset_n_in && !flush_in && ((state_q == EMPTY) || issue);
  assign accept  = dec_valid_in && dec_ready_out;
  assign bad_ins = invalid_ins_in || (exec_unit_sel_in == 3'b000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = bad_ins ? EXC : HELD;
      HELD: begin
        if (flush_in)    state_d = EMPTY;
        else if (accept) state_d = bad_ins ? EXC : HELD;
        else if (issue)  state_d = EMPTY;
      end
      EXC:     if (exc_ack_in) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= EMPTY;
      held_q  <= '0;
      pend_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept && !bad_ins) held_q <= dec_ins;
      if (state_q == HELD && !issue && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  always_comb begin
    issue_valid_out = issue;
    issue_sel_out   = '0;
    issue_uop_out   = '0;
    issue_rd_out    = '0;
    issue_rd_we_out = 1'b0;
    if (state_q == HELD) begin
      issue_sel_out   = held_q.sel;
      issue_uop_out   = held_q.uop;
      issue_rd_out    = held_q.rd;
      issue_rd_we_out = held_q.rd_we;
    end
  end

  assign exc_valid_out   = (state_q == EXC);
  assign stall_count_out = stall_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: table of single-instruction vectors plus directed
// sequences for hazards, stalls, flush, exceptions and reset. Expected issue
// fields are queued when an instruction is offered and checked on each issue.
module tb_issue_scheduler;

  logic        clock_in = 1'b0, reset_n_in = 1'b0;
  logic        dec_valid_in = 1'b0, dec_ready_out;
  logic [2:0]  exec_unit_sel_in = '0;
  logic [3:0]  exec_unit_uop_in = '0;
  logic        rd_write_enable_in = 1'b0;
  logic [4:0]  rd_addr_in = '0, rs1_addr_in = '0, rs2_addr_in = '0;
  logic        invalid_ins_in = 1'b0;
  logic        int_ready_in = 1'b1, bru_ready_in = 1'b1, lsu_ready_in = 1'b1, vec_ready_in = 1'b1;
  logic        issue_valid_out, issue_rd_we_out;
  logic [2:0]  issue_sel_out;
  logic [3:0]  issue_uop_out;
  logic [4:0]  issue_rd_out;
  logic        wb_valid_in = 1'b0;
  logic [4:0]  wb_rd_in = '0;
  logic        flush_in = 1'b0, exc_valid_out, exc_ack_in = 1'b0;
  logic [15:0] stall_count_out;

  issue_scheduler #(.NREGS(32)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .exec_unit_sel_in(exec_unit_sel_in), .exec_unit_uop_in(exec_unit_uop_in),
    .rd_write_enable_in(rd_write_enable_in), .rd_addr_in(rd_addr_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .invalid_ins_in(invalid_ins_in),
    .int_ready_in(int_ready_in), .bru_ready_in(bru_ready_in),
    .lsu_ready_in(lsu_ready_in), .vec_ready_in(vec_ready_in),
    .issue_valid_out(issue_valid_out), .issue_sel_out(issue_sel_out),
    .issue_uop_out(issue_uop_out), .issue_rd_out(issue_rd_out), .issue_rd_we_out(issue_rd_we_out),
    .wb_valid_in(wb_valid_in), .wb_rd_in(wb_rd_in), .flush_in(flush_in),
    .exc_valid_out(exc_valid_out), .exc_ack_in(exc_ack_in), .stall_count_out(stall_count_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] uop;
    logic [4:0] rd;
    logic       we;
  } iss_t;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] uop;
    logic [4:0] rd;
    logic       we;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] rdy;   // {int, bru, lsu, vec}
    logic       exp;   // issues in its first HELD cycle
  } vec_t;

  iss_t sb_q[$];
  iss_t mon_a, mon_e;
  int   total = 0, bad = 0;
  int   exp_stall = 0;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every issue pulse must match the oldest queued expectation.
  always @(negedge clock_in) begin
    if (issue_valid_out === 1'b1) begin
      mon_a = '{sel: issue_sel_out, uop: issue_uop_out, rd: issue_rd_out, we: issue_rd_we_out};
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_issue got=%0h exp=none t=%0t", mon_a, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("issue_fields", 32'(mon_a), 32'(mon_e));
      end
    end
  end

  task automatic tick(); @(posedge clock_in); #1; endtask
  task automatic at_neg(); @(negedge clock_in); #1; endtask

  task automatic drive(input logic [2:0] sel, input logic [3:0] uop, input logic [4:0] rd,
                       input logic we, input logic [4:0] rs1, input logic [4:0] rs2, input logic inv);
    dec_valid_in = 1'b1; exec_unit_sel_in = sel; exec_unit_uop_in = uop; rd_addr_in = rd;
    rd_write_enable_in = we; rs1_addr_in = rs1; rs2_addr_in = rs2; invalid_ins_in = inv;
  endtask

  task automatic idle(); dec_valid_in = 1'b0; invalid_ins_in = 1'b0; endtask

  task automatic push(input logic [2:0] sel, input logic [3:0] uop, input logic [4:0] rd, input logic we);
    sb_q.push_back('{sel: sel, uop: uop, rd: rd, we: we});
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid_in = 1'b1; wb_rd_in = rd; tick(); wb_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'b001, 4'd1, 5'd3,  1'b1, 5'd1, 5'd2, 4'b1000, 1'b1};
    tbl[1] = '{3'b011, 4'd2, 5'd0,  1'b0, 5'd1, 5'd2, 4'b0100, 1'b1};
    tbl[2] = '{3'b010, 4'd3, 5'd4,  1'b1, 5'd7, 5'd2, 4'b0010, 1'b1};
    tbl[3] = '{3'b100, 4'd4, 5'd31, 1'b1, 5'd1, 5'd9, 4'b0001, 1'b1};
    tbl[4] = '{3'b001, 4'd5, 5'd3,  1'b1, 5'd1, 5'd2, 4'b0111, 1'b0};
    tbl[5] = '{3'b011, 4'd6, 5'd0,  1'b0, 5'd1, 5'd2, 4'b1011, 1'b0};
    tbl[6] = '{3'b010, 4'd7, 5'd12, 1'b1, 5'd1, 5'd2, 4'b1101, 1'b0};
    tbl[7] = '{3'b100, 4'd8, 5'd0,  1'b1, 5'd1, 5'd2, 4'b1110, 1'b0};
    tbl[8] = '{3'b001, 4'd9, 5'd0,  1'b1, 5'd0, 5'd0, 4'b1111, 1'b1};

    // Reset state
    #2;
    chk("rst_dec_ready", 32'(dec_ready_out), 0);
    chk("rst_issue", 32'(issue_valid_out), 0);
    chk("rst_exc", 32'(exc_valid_out), 0);
    chk("rst_stall", 32'(stall_count_out), 0);
    chk("rst_sel", 32'(issue_sel_out), 0);
    repeat (2) @(posedge clock_in);
    #1 reset_n_in = 1'b1;
    at_neg();
    chk("post_rst_dec_ready", 32'(dec_ready_out), 1);

    // Table: one instruction each, routed by unit select and readiness.
    for (int i = 0; i < 9; i++) begin
      {int_ready_in, bru_ready_in, lsu_ready_in, vec_ready_in} = tbl[i].rdy;
      drive(tbl[i].sel, tbl[i].uop, tbl[i].rd, tbl[i].we, tbl[i].rs1, tbl[i].rs2, 1'b0);
      if (tbl[i].exp) push(tbl[i].sel, tbl[i].uop, tbl[i].rd, tbl[i].we);
      tick(); idle();
      at_neg();
      chk("tbl_issue", 32'(issue_valid_out), 32'(tbl[i].exp));
      chk("tbl_dec_ready", 32'(dec_ready_out), 32'(tbl[i].exp));
      chk("tbl_sel_held", 32'(issue_sel_out), 32'(tbl[i].sel));
      if (!tbl[i].exp) begin
        exp_stall++;
        tick();
        {int_ready_in, bru_ready_in, lsu_ready_in, vec_ready_in} = 4'b1111;
        push(tbl[i].sel, tbl[i].uop, tbl[i].rd, tbl[i].we);
        at_neg();
        chk("tbl_late_issue", 32'(issue_valid_out), 1);
      end
      tick();
      if (tbl[i].we && tbl[i].rd != 5'd0) wb(tbl[i].rd);
      chk("tbl_drain", 32'(sb_q.size()), 0);
      sb_q.delete();
    end
    {int_ready_in, bru_ready_in, lsu_ready_in, vec_ready_in} = 4'b1111;
    chk("tbl_stall_count", 32'(stall_count_out), 32'(exp_stall));

    // ADD x5 then dependent SUB: RAW stall, released by writeback bypass.
    drive(3'b001, 4'd1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0);
    push(3'b001, 4'd1, 5'd5, 1'b1);
    tick();
    drive(3'b001, 4'd2, 5'd6, 1'b1, 5'd5, 5'd0, 1'b0);
    at_neg();
    chk("add_issue", 32'(issue_valid_out), 1);
    chk("add_dec_ready", 32'(dec_ready_out), 1);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("sub_stall_issue", 32'(issue_valid_out), 0);
      chk("sub_stall_ready", 32'(dec_ready_out), 0);
      tick(); exp_stall++;
    end
    chk("sub_stall_count", 32'(stall_count_out), 32'(exp_stall));
    wb_valid_in = 1'b1; wb_rd_in = 5'd5;
    push(3'b001, 4'd2, 5'd6, 1'b1);
    at_neg();
    chk("sub_wb_bypass", 32'(issue_valid_out), 1);
    tick(); wb_valid_in = 1'b0;

    // rd_we=0 on a pending rd is no hazard; rd_we=1 is.
    drive(3'b100, 4'd3, 5'd6, 1'b0, 5'd0, 5'd0, 1'b0);
    push(3'b100, 4'd3, 5'd6, 1'b0);
    tick(); idle();
    at_neg();
    chk("we0_no_hazard", 32'(issue_valid_out), 1);
    tick();
    drive(3'b001, 4'd4, 5'd6, 1'b1, 5'd0, 5'd0, 1'b0);
    tick(); idle();
    at_neg();
    chk("waw_stall", 32'(issue_valid_out), 0);
    tick(); exp_stall++;
    // Issue writing x6 in the same cycle as wb of x6: the set wins.
    wb_valid_in = 1'b1; wb_rd_in = 5'd6;
    push(3'b001, 4'd4, 5'd6, 1'b1);
    at_neg();
    chk("waw_issue", 32'(issue_valid_out), 1);
    tick(); wb_valid_in = 1'b0;
    drive(3'b001, 4'd5, 5'd0, 1'b0, 5'd1, 5'd6, 1'b0);
    tick(); idle();
    at_neg();
    chk("set_beats_wb", 32'(issue_valid_out), 0);
    tick(); exp_stall++;
    wb_valid_in = 1'b1; wb_rd_in = 5'd6;
    push(3'b001, 4'd5, 5'd0, 1'b0);
    at_neg();
    chk("rs2_release", 32'(issue_valid_out), 1);
    tick(); wb_valid_in = 1'b0;

    // LW held by a busy LSU for 3 cycles.
    lsu_ready_in = 1'b0;
    drive(3'b010, 4'd6, 5'd8, 1'b1, 5'd1, 5'd2, 1'b0);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("lw_wait_issue", 32'(issue_valid_out), 0);
      chk("lw_wait_ready", 32'(dec_ready_out), 0);
      tick(); exp_stall++;
    end
    lsu_ready_in = 1'b1;
    push(3'b010, 4'd6, 5'd8, 1'b1);
    at_neg();
    chk("lw_issue", 32'(issue_valid_out), 1);
    tick();
    wb(5'd8);
    chk("lw_stall_count", 32'(stall_count_out), 32'(exp_stall));

    // Flush suppresses an otherwise ready issue and the decode handshake.
    int_ready_in = 1'b0;
    drive(3'b001, 4'd7, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0);
    tick(); idle();
    at_neg();
    tick();
    int_ready_in = 1'b1; flush_in = 1'b1;
    drive(3'b001, 4'd8, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    at_neg();
    chk("flush_no_issue", 32'(issue_valid_out), 0);
    chk("flush_dec_ready", 32'(dec_ready_out), 0);
    tick(); flush_in = 1'b0; idle();
    at_neg();
    chk("flush_empty_ready", 32'(dec_ready_out), 1);
    chk("flush_empty_sel", 32'(issue_sel_out), 0);

    // Flush keeps scoreboard bits.
    drive(3'b001, 4'd9, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0);
    push(3'b001, 4'd9, 5'd9, 1'b1);
    tick(); idle();
    at_neg(); tick();
    drive(3'b011, 4'd10, 5'd0, 1'b0, 5'd9, 5'd0, 1'b0);
    tick(); idle();
    flush_in = 1'b1;
    at_neg();
    chk("flush_hazard_issue", 32'(issue_valid_out), 0);
    tick(); flush_in = 1'b0;
    drive(3'b011, 4'd11, 5'd0, 1'b0, 5'd9, 5'd0, 1'b0);
    tick(); idle();
    at_neg();
    chk("flush_sb_kept", 32'(issue_valid_out), 0);
    tick();
    wb_valid_in = 1'b1; wb_rd_in = 5'd9;
    push(3'b011, 4'd11, 5'd0, 1'b0);
    at_neg();
    chk("flush_sb_release", 32'(issue_valid_out), 1);
    tick(); wb_valid_in = 1'b0;

    // sel 000 -> EXC, flush ignored, leaves on ack.
    drive(3'b000, 4'd1, 5'd10, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(3'b001, 4'd2, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    at_neg();
    chk("exc_valid", 32'(exc_valid_out), 1);
    chk("exc_dec_ready", 32'(dec_ready_out), 0);
    chk("exc_no_issue", 32'(issue_valid_out), 0);
    tick(); flush_in = 1'b1;
    at_neg();
    chk("exc_flush_ignored", 32'(exc_valid_out), 1);
    tick(); flush_in = 1'b0; exc_ack_in = 1'b1; idle();
    at_neg();
    chk("exc_ack_cycle", 32'(exc_valid_out), 1);
    tick(); exc_ack_in = 1'b0;
    at_neg();
    chk("exc_exit", 32'(exc_valid_out), 0);
    chk("exc_exit_ready", 32'(dec_ready_out), 1);
    // invalid_ins_in path; the faulting rd must not become pending.
    drive(3'b001, 4'd3, 5'd10, 1'b1, 5'd0, 5'd0, 1'b1);
    tick(); idle();
    at_neg();
    chk("inv_exc", 32'(exc_valid_out), 1);
    exc_ack_in = 1'b1;
    tick(); exc_ack_in = 1'b0;
    drive(3'b001, 4'd4, 5'd0, 1'b0, 5'd10, 5'd0, 1'b0);
    push(3'b001, 4'd4, 5'd0, 1'b0);
    tick(); idle();
    at_neg();
    chk("exc_no_sb", 32'(issue_valid_out), 1);
    tick();

    // Reset during a hazard stall.
    drive(3'b001, 4'd5, 5'd11, 1'b1, 5'd0, 5'd0, 1'b0);
    push(3'b001, 4'd5, 5'd11, 1'b1);
    tick(); idle();
    at_neg(); tick();
    drive(3'b001, 4'd6, 5'd12, 1'b1, 5'd11, 5'd0, 1'b0);
    tick(); idle();
    at_neg();
    chk("pre_rst_stall", 32'(issue_valid_out), 0);
    #2 reset_n_in = 1'b0;
    #1;
    chk("mid_rst_issue", 32'(issue_valid_out), 0);
    chk("mid_rst_ready", 32'(dec_ready_out), 0);
    chk("mid_rst_stall", 32'(stall_count_out), 0);
    chk("mid_rst_fields", 32'({issue_sel_out, issue_uop_out, issue_rd_out, issue_rd_we_out}), 0);
    chk("mid_rst_exc", 32'(exc_valid_out), 0);
    tick(); tick();
    reset_n_in = 1'b1;
    at_neg();
    chk("post_rst2_ready", 32'(dec_ready_out), 1);
    drive(3'b001, 4'd7, 5'd0, 1'b0, 5'd11, 5'd0, 1'b0);
    push(3'b001, 4'd7, 5'd0, 1'b0);
    tick(); idle();
    at_neg();
    chk("post_rst_sb_clear", 32'(issue_valid_out), 1);
    tick();
    chk("final_drain", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
